imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes the MIPS core's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written into instruction memory at the byte-address stride the fetch stage's PC+4 adder reads it back with. The core is held in reset until a complete program with a correct checksum has been written.

## Interface
- ADDR_W, 8: instruction-memory address width (matches the 8-bit PC).
- BASE_ADDR, 8'd0: address of word 0.
- ADDR_STRIDE, 4: address increment per word (matches PC+4).
- MAX_WORDS, 50: largest legal word count; (MAX_WORDS-1)*ADDR_STRIDE+BASE_ADDR ≤ 199.
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load session.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts byte_in this cycle.
- mem_addr  out  ADDR_W  write address to instruction memory.
- mem_data  out  32  write data to instruction memory.
- mem_we  out  1  one-cycle write strobe.
- core_rst  out  1  hold-reset for the pipeline (PC, IF/ID and later stages).
- done  out  1  program loaded and checksum good.
- error  out  1  bad length or checksum.
- word_count  out  8  words written in the current session.

## Operation
- Stream format: length byte N, then 4N data bytes (first byte = bits 31:24 of word 0), then one checksum byte = XOR of all 4N data bytes. The length byte is not included in the checksum.
- A byte transfers on a cycle with byte_valid && byte_ready. byte_in is ignored otherwise.
- States:
  - IDLE: byte_ready=0. On start, go to LEN.
  - LEN: byte_ready=1. On a transfer, if N==0 or N>MAX_WORDS go to ERROR. Otherwise latch N, clear the word index, byte index and checksum, and go to DATA.
  - DATA: byte_ready=1. Each transfer shifts the byte into a 32-bit shift register (shift left 8) and XORs it into the checksum. On the 4th byte of a word, go to WRITE.
  - WRITE: byte_ready=0. mem_we=1, mem_addr=BASE_ADDR+idx*ADDR_STRIDE (truncated to ADDR_W), mem_data=assembled word. word_count increments. Next state is CSUM if idx+1==N, else DATA.
  - CSUM: byte_ready=1. On a transfer, go to DONE if the byte equals the checksum, else go to ERROR.
  - DONE: done=1, core_rst=0.
  - ERROR: error=1, core_rst=1.
- start in DONE or ERROR goes to LEN, clears done, error and word_count, and reasserts core_rst. start in LEN/DATA/WRITE/CSUM is ignored.
- core_rst is 1 in every state except DONE.
- Integration: the memory read enable for fetch is gated off while core_rst=1, so mem_we drives the memory's write port.
- Words already written are never erased. An aborted session leaves partial contents.

## Timing
- Reset values: state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_data=0, core_rst=1, done=0, error=0, word_count=0.
- All outputs are registered.
- mem_we rises on the cycle after the 4th byte of a word transfers and is high for exactly one cycle.
- Minimum cost per word is 5 cycles (4 byte cycles + 1 WRITE cycle).
- done/error assert on the cycle after the checksum/length byte transfers.
- Reset mid-session forces the reset values on the next edge; no further mem_we.
- start coincident with rst: rst wins.
- A byte held valid during WRITE is accepted on the following DATA/CSUM cycle, never duplicated or lost.

## Structure
- mips_pkg holds the loader state encoding (IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR), MAX_WORDS, and the PC stride constant 4, shared with fetch.
- One natural sub-module: byte_packer. It holds the 4-byte shift register, byte index and XOR checksum, with a clear input and a word_full output.
- The FSM, address counter and word_count stay in imem_loader.

## Test plan
- Stream 02, 00 22 18 20, 00 00 00 00, 1A with byte_valid always high -> writes 0x00221820 @0x00 and 0x00000000 @0x04, one mem_we each; done=1, core_rst=0, word_count=2.
- Same stream with checksum 1B -> both writes occur; error=1, done=0, core_rst stays 1.
- Length byte 00, and separately length byte 33 (51) -> error=1 one cycle later, no mem_we, byte_ready=0.
- Random byte_valid gaps plus a byte held across each WRITE cycle -> identical writes and order as the gap-free run, no duplicated byte.
- rst pulse after the 6th data byte of an N=3 stream -> word 0 written only, all outputs return to reset values. Then start plus a full N=1 stream -> word written @BASE_ADDR, done=1.
- N=50 stream -> last write @0xC4 (196), done=1. start in DONE -> core_rst=1, done=0, word_count=0, byte_ready=1.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Loader state encoding and constants shared with the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  // Byte distance between consecutive instructions (PC+4 adder in fetch).
  localparam int PC_STRIDE     = 4;
  localparam int LDR_MAX_WORDS = 50;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } ldr_state_t;

endpackage

`default_nettype wire

// File: rtl/byte_packer.sv
// ============================================================================
// Module      : byte_packer
// Description : Big-endian word assembly from a byte stream plus XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [7:0]  o_csum,
  output logic        o_word_full
);

  // Only the three earlier bytes need storage; the fourth completes the word
  // on the same cycle it is pushed.
  logic [23:0] r_shift;
  logic [1:0]  r_idx;
  logic [7:0]  r_csum;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_csum  <= '0;
    end else if (i_push) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_idx   <= r_idx + 2'd1;
      r_csum  <= r_csum ^ i_byte;
    end
  end

  assign o_word      = {r_shift, i_byte};
  assign o_csum      = r_csum;
  assign o_word_full = i_push && (r_idx == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Boot loader writing instruction memory from a checksummed byte
//               stream; holds the core in reset until a good program is loaded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
  import mips_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                ADDR_STRIDE = PC_STRIDE,
  parameter int                MAX_WORDS   = LDR_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              mem_we,
  output logic              core_rst,
  output logic              done,
  output logic              error,
  output logic [7:0]        word_count
);

  localparam logic [7:0]        c_max_n  = 8'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] c_stride = ADDR_W'(ADDR_STRIDE);

  ldr_state_t        r_state;
  ldr_state_t        w_state_nxt;
  logic              r_byte_ready;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_data;
  logic              r_mem_we;
  logic              r_core_rst;
  logic              r_done;
  logic              r_error;
  logic [7:0]        r_word_count;
  logic [7:0]        r_len;
  logic [7:0]        r_widx;
  logic [ADDR_W-1:0] r_addr;

  logic              w_xfer;
  logic              w_len_ok;
  logic              w_push;
  logic              w_clear;
  logic [31:0]       w_word;
  logic [7:0]        w_csum;
  logic              w_word_full;

  assign w_xfer   = byte_valid && r_byte_ready;
  assign w_len_ok = (byte_in != 8'd0) && (byte_in <= c_max_n);
  assign w_push   = (r_state == S_DATA) && w_xfer;
  assign w_clear  = (r_state == S_LEN) && w_xfer && w_len_ok;

  byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_push      (w_push),
    .i_byte      (byte_in),
    .o_word      (w_word),
    .o_csum      (w_csum),
    .o_word_full (w_word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LEN;
      S_LEN:   if (w_xfer) w_state_nxt = w_len_ok ? S_DATA : S_ERROR;
      S_DATA:  if (w_word_full) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = (r_widx + 8'd1 == r_len) ? S_CSUM : S_DATA;
      S_CSUM:  if (w_xfer) w_state_nxt = (byte_in == w_csum) ? S_DONE : S_ERROR;
      S_DONE,
      S_ERROR: if (start) w_state_nxt = S_LEN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state
  // they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_ready <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_mem_we     <= 1'b0;
      r_core_rst   <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
      r_len        <= '0;
      r_widx       <= '0;
      r_addr       <= BASE_ADDR;
    end else begin
      r_byte_ready <= (w_state_nxt == S_LEN) || (w_state_nxt == S_DATA) ||
                      (w_state_nxt == S_CSUM);
      r_mem_we     <= (w_state_nxt == S_WRITE);
      r_core_rst   <= (w_state_nxt != S_DONE);
      r_done       <= (w_state_nxt == S_DONE);
      r_error      <= (w_state_nxt == S_ERROR);
      if (w_state_nxt == S_WRITE) begin
        r_mem_addr   <= r_addr;
        r_mem_data   <= w_word;
        r_word_count <= r_word_count + 8'd1;
      end
      if (w_clear) begin
        r_len  <= byte_in;
        r_widx <= '0;
        r_addr <= BASE_ADDR;
      end
      if (r_state == S_WRITE) begin
        r_widx <= r_widx + 8'd1;
        r_addr <= r_addr + c_stride;
      end
      if (start && ((r_state == S_DONE) || (r_state == S_ERROR)))
        r_word_count <= '0;
    end
  end

  assign byte_ready = r_byte_ready;
  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;
  assign mem_we     = r_mem_we;
  assign core_rst   = r_core_rst;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic        core_rst;
  logic        done;
  logic        error;
  logic [7:0]  word_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  wa[$];
  logic [31:0] wd[$];

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte, optionally after idle cycles, and return #1 after the
  // edge on which it transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk); #1;
        break;
      end
      t++;
      if (t > 20) begin
        n_checks++;
        n_errors++;
        $error("FAIL handshake_timeout observed=%h expected=ready", b);
        break;
      end
    end
  endtask

  task automatic send_seq(input logic [7:0] q[$], input bit gaps);
    foreach (q[i]) send_byte(q[i], gaps ? int'($urandom_range(0, 3)) : 0);
    byte_valid = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic chk_two_words(input string tag);
    chk({tag, "_nwrites"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk({tag, "_a0"}, {24'd0, wa[0]}, 32'h00);
      chk({tag, "_d0"}, wd[0], 32'h00221820);
      chk({tag, "_a1"}, {24'd0, wa[1]}, 32'h04);
      chk({tag, "_d1"}, wd[1], 32'h00000000);
    end
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] cs;
    rst = 1'b1; start = 1'b0; byte_in = '0; byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_addr",  {24'd0, mem_addr}, 32'd0);
    chk("rst_data",  mem_data, 32'd0);
    chk("rst_core",  {31'd0, core_rst}, 32'd1);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_err",   {31'd0, error}, 32'd0);
    chk("rst_wc",    {24'd0, word_count}, 32'd0);
    @(posedge clk); #1;

    // Good two-word program, byte_valid held high throughout.
    clear_log();
    pulse_start();
    chk("len_ready", {31'd0, byte_ready}, 32'd1);
    s = '{8'h02, 8'h00, 8'h22, 8'h18, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1A};
    send_seq(s, 1'b0);
    chk("a_done", {31'd0, done}, 32'd1);
    chk("a_core", {31'd0, core_rst}, 32'd0);
    chk("a_err",  {31'd0, error}, 32'd0);
    chk("a_wc",   {24'd0, word_count}, 32'd2);
    chk("a_ready", {31'd0, byte_ready}, 32'd0);
    chk_two_words("a");

    // Restart from DONE, then bad checksum.
    clear_log();
    pulse_start();
    chk("b_start_core", {31'd0, core_rst}, 32'd1);
    chk("b_start_done", {31'd0, done}, 32'd0);
    chk("b_start_wc",   {24'd0, word_count}, 32'd0);
    s[9] = 8'h1B;
    send_seq(s, 1'b0);
    chk("b_err",  {31'd0, error}, 32'd1);
    chk("b_done", {31'd0, done}, 32'd0);
    chk("b_core", {31'd0, core_rst}, 32'd1);
    chk_two_words("b");

    // Illegal lengths.
    clear_log();
    pulse_start();
    chk("z_start_err", {31'd0, error}, 32'd0);
    send_byte(8'h00, 0); byte_valid = 1'b0;
    chk("z_err",   {31'd0, error}, 32'd1);
    chk("z_ready", {31'd0, byte_ready}, 32'd0);
    pulse_start();
    send_byte(8'h33, 0); byte_valid = 1'b0;
    chk("big_err",   {31'd0, error}, 32'd1);
    chk("big_ready", {31'd0, byte_ready}, 32'd0);
    repeat (2) @(posedge clk); #1;
    chk("len_err_nwrites", 32'(wa.size()), 32'd0);

    // Same good program with random gaps between bytes.
    clear_log();
    pulse_start();
    s[9] = 8'h1A;
    send_seq(s, 1'b1);
    chk("g_done", {31'd0, done}, 32'd1);
    chk_two_words("g");

    // Reset in the middle of an N=3 stream; start coincides with rst.
    clear_log();
    pulse_start();
    s = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_seq(s, 1'b0);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("r_ready", {31'd0, byte_ready}, 32'd0);
    chk("r_addr",  {24'd0, mem_addr}, 32'd0);
    chk("r_data",  mem_data, 32'd0);
    chk("r_core",  {31'd0, core_rst}, 32'd1);
    chk("r_wc",    {24'd0, word_count}, 32'd0);
    byte_valid = 1'b1; byte_in = 8'h77;
    repeat (4) @(posedge clk); #1;
    byte_valid = 1'b0;
    chk("r_nwrites", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) chk("r_d0", wd[0], 32'h11223344);
    clear_log();
    pulse_start();
    s = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    send_seq(s, 1'b0);
    chk("r1_done", {31'd0, done}, 32'd1);
    chk("r1_nwrites", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("r1_a0", {24'd0, wa[0]}, 32'h00);
      chk("r1_d0", wd[0], 32'hAABBCCDD);
    end

    // Largest legal program: word i = {i, A5, 00, 3C}.
    clear_log();
    pulse_start();
    s = '{8'd50};
    cs = 8'h00;
    for (int i = 0; i < 50; i++) begin
      s.push_back(8'(i)); s.push_back(8'hA5); s.push_back(8'h00); s.push_back(8'h3C);
      cs = cs ^ 8'(i) ^ 8'hA5 ^ 8'h3C;
    end
    s.push_back(cs);
    send_seq(s, 1'b0);
    chk("m_done", {31'd0, done}, 32'd1);
    chk("m_wc",   {24'd0, word_count}, 32'd50);
    chk("m_nwrites", 32'(wa.size()), 32'd50);
    if (wa.size() == 50) begin
      chk("m_a49", {24'd0, wa[49]}, 32'hC4);
      chk("m_d49", wd[49], 32'h31A5003C);
      chk("m_a10", {24'd0, wa[10]}, 32'h28);
    end
    pulse_start();
    chk("m_start_core",  {31'd0, core_rst}, 32'd1);
    chk("m_start_done",  {31'd0, done}, 32'd0);
    chk("m_start_wc",    {24'd0, word_count}, 32'd0);
    chk("m_start_ready", {31'd0, byte_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
